vid_pattern_gen: RTL
====================

# vid_pattern_gen

Video timing and test-pattern source for the vid_io pixel stream. It produces `o_vid_data`, `o_vid_hsync`, `o_vid_vsync` and `o_vid_VDE` with programmable raster timing. Its output feeds the pixel-processing stages (colour manipulation, filters) in place of the camera path, for bring-up and for bench stimulus. It is the transmitting end of the vid_io interface those stages consume.

## Interface
- `DATA_WIDTH`, 24: pixel width, packed {R[23:16], B[15:8], G[7:0]}.
- `H_ACTIVE`, 1280: active pixels per line.
- `H_FP`, 110 / `H_SYNC`, 40 / `H_BP`, 220: horizontal front porch, sync and back porch, in pixels.
- `V_ACTIVE`, 720: active lines per frame.
- `V_FP`, 5 / `V_SYNC`, 5 / `V_BP`, 20: vertical front porch, sync and back porch, in lines.
- `SYNC_POL`, 1: 1 means sync is asserted high; 0 means sync is asserted low.
- `clk`  in  1  pixel clock.
- `n_rst`  in  1  reset. Asynchronous, active-low.
- `i_enable`  in  1  run request. Sampled only at frame boundaries.
- `i_pattern`  in  2  pattern select: 0 = colour bars, 1 = grey ramp, 2 = solid, 3 = checkerboard.
- `i_solid_colour`  in  DATA_WIDTH  colour used by pattern 2.
- `o_vid_data`  out  DATA_WIDTH  pixel data. Zero whenever `o_vid_VDE`=0.
- `o_vid_hsync`, `o_vid_vsync`  out  1  sync outputs, polarity set by `SYNC_POL`.
- `o_vid_VDE`  out  1  active-video flag.
- `o_frame_start`  out  1  one-cycle pulse coincident with pixel (0,0) of each frame.

## Operation
- Derived constants: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
- Counter widths are `$clog2` of the totals.
- FSM has two states, IDLE and RUN.
  - IDLE: counters are held at 0. Outputs sit at their inactive levels: sync deasserted, VDE=0, data=0.
  - IDLE→RUN: on a clock edge where `i_enable`=1. `i_pattern` and `i_solid_colour` are latched on that edge.
  - RUN: `h_cnt` increments every cycle and wraps at H_TOTAL-1. `v_cnt` increments on each h wrap and wraps at V_TOTAL-1.
  - At the frame wrap (h=H_TOTAL-1, v=V_TOTAL-1): if `i_enable`=0 the FSM goes to IDLE. Otherwise it stays in RUN and re-latches the pattern inputs.
  - Pattern changes never take effect mid-frame.
- Region decode:
  - active = h<H_ACTIVE and v<V_ACTIVE.
  - hsync is asserted for H_ACTIVE+H_FP ≤ h < H_ACTIVE+H_FP+H_SYNC, on every line including blanking lines.
  - vsync is asserted for V_ACTIVE+V_FP ≤ v < V_ACTIVE+V_FP+V_SYNC, for whole lines.
- Patterns (active pixels only):
  - Bars: BAR_W = H_ACTIVE/8 (integer division). A bar index steps every BAR_W pixels and saturates at 7, so the last bar absorbs any remainder. Bar order is white, yellow, cyan, green, magenta, red, blue, black. Channel levels are 8'hFF or 8'h00.
  - Ramp: R=G=B=h[7:0], wrapping every 256 pixels.
  - Solid: the latched `i_solid_colour`.
  - Checker: white when h[5]^v[5]=0, black otherwise (32×32 squares).

## Timing
- Reset values: `o_vid_data`=0, `o_vid_VDE`=0, `o_frame_start`=0, `o_vid_hsync`=`o_vid_vsync`=~SYNC_POL. FSM in IDLE, counters at 0.
- All outputs are registered. The outputs on cycle n+1 reflect the counter values of cycle n, so latency is 1 cycle.
- First frame: if `i_enable` is high at edge E (IDLE→RUN), then counter (0,0) occurs in the cycle after E. That pixel appears on the outputs, with `o_frame_start`=1, one edge later.
- Frame period in RUN is exactly H_TOTAL×V_TOTAL cycles, with no gaps between consecutive frames.
- Deasserting `i_enable` mid-frame has no effect until the frame wrap. The frame always completes, including its full vertical blanking.
- Asserting `n_rst` mid-frame forces the reset values immediately (asynchronously). After release the block restarts from IDLE.
- `i_pattern` changes outside the frame wrap are ignored for the current frame.

## Structure
- Shared package `vid_pkg`: pattern encodings (PAT_BARS=0, PAT_RAMP=1, PAT_SOLID=2, PAT_CHECKER=3), the 8 bar colour constants in {R,B,G} packing, and the default 720p timing constants.
- One sub-module: `vid_timing_gen`. It owns the counters, the FSM and the region decode, and outputs h, v, active, hsync, vsync and frame_start.
- The top-level module adds the pattern mux and the output register stage.

## Test plan
- All scenarios use small timing: H 16/2/3/3 (total 24), V 4/1/2/1 (total 8), `SYNC_POL`=1.
1. Reset, then hold `i_enable`=1 with pattern 0. Require:
   - `o_frame_start` pulses every 192 cycles.
   - VDE high for 16 of every 24 cycles on lines 0–3 only.
   - hsync high for 3 cycles starting 2 cycles after VDE falls.
   - vsync high for lines 5–6.
2. Bars with H_ACTIVE=16 (BAR_W=2): pixels 0,1 read 24'hFFFFFF; pixels 2,3 read yellow {FF,00,FF}; pixels 14,15 read 0.
3. Ramp: pixel h of every active line reads {h,h,h}. Blanking pixels read 0.
4. Solid pattern with `i_solid_colour`=24'h123456, changed to 24'hABCDEF mid-frame: the current frame stays 24'h123456; the next frame reads 24'hABCDEF.
5. Drop `i_enable` at line 1: the frame completes through line 7, then the outputs go idle with no further `o_frame_start`. Re-raising `i_enable` restarts with a clean frame.
6. Assert `n_rst` mid-line while VDE=1: VDE, data and sync drop in the same cycle, without waiting for a clock edge. After release the block stays idle until `i_enable`=1.
7. Repeat scenario 1 with `SYNC_POL`=0: the sync outputs are inverted and everything else is unchanged.

Source files
------------

// File: rtl/vid_pkg.sv
// vid_pkg: pattern encodings, colour-bar constants ({R,B,G} packing) and
// default 720p raster timing shared by the vid_io blocks.
package vid_pkg;

    typedef enum logic [1:0] {
        PAT_BARS    = 2'd0,
        PAT_RAMP    = 2'd1,
        PAT_SOLID   = 2'd2,
        PAT_CHECKER = 2'd3
    } pattern_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam logic [23:0] BAR_WHITE   = 24'hFFFFFF;
    localparam logic [23:0] BAR_YELLOW  = 24'hFF00FF;
    localparam logic [23:0] BAR_CYAN    = 24'h00FFFF;
    localparam logic [23:0] BAR_GREEN   = 24'h0000FF;
    localparam logic [23:0] BAR_MAGENTA = 24'hFFFF00;
    localparam logic [23:0] BAR_RED     = 24'hFF0000;
    localparam logic [23:0] BAR_BLUE    = 24'h00FF00;
    localparam logic [23:0] BAR_BLACK   = 24'h000000;

    localparam logic [23:0] BAR_COLOUR [8] = '{
        BAR_WHITE, BAR_YELLOW, BAR_CYAN, BAR_GREEN,
        BAR_MAGENTA, BAR_RED, BAR_BLUE, BAR_BLACK
    };

    localparam int DEF_H_ACTIVE = 1280;
    localparam int DEF_H_FP     = 110;
    localparam int DEF_H_SYNC   = 40;
    localparam int DEF_H_BP     = 220;
    localparam int DEF_V_ACTIVE = 720;
    localparam int DEF_V_FP     = 5;
    localparam int DEF_V_SYNC   = 5;
    localparam int DEF_V_BP     = 20;

endpackage

// File: rtl/vid_pattern_gen_if.sv
// vid_pattern_gen_if: vid_io pixel stream; master drives it, downstream stages take the slave view.
interface vid_pattern_gen_if #(
    parameter int DATA_WIDTH = 24
);
    logic [DATA_WIDTH-1:0] o_vid_data;
    logic                  o_vid_hsync;
    logic                  o_vid_vsync;
    logic                  o_vid_VDE;
    logic                  o_frame_start;

    modport master (output o_vid_data, o_vid_hsync, o_vid_vsync, o_vid_VDE, o_frame_start);
    modport slave  (input  o_vid_data, o_vid_hsync, o_vid_vsync, o_vid_VDE, o_frame_start);
endinterface

// File: rtl/vid_timing_gen.sv
// vid_timing_gen: raster counters, IDLE/RUN control and active/sync region decode.
// Outputs are combinational from the counters; the parent registers them.
module vid_timing_gen
    import vid_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    localparam int HW = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP),
    localparam int VW = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
    input  logic          clk,
    input  logic          n_rst,
    input  logic          i_enable,
    output logic [HW-1:0] h,
    output logic [VW-1:0] v,
    output logic          active,
    output logic          hsync,
    output logic          vsync,
    output logic          frame_start,
    output logic          load
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    state_e        state_q, state_d;
    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic          run, h_wrap, f_wrap;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            h_q     <= '0;
            v_q     <= '0;
        end else begin
            state_q <= state_d;
            h_q     <= h_d;
            v_q     <= v_d;
        end
    end

    // i_enable only matters in IDLE or on the frame wrap, so a frame always completes
    always_comb begin
        run     = state_q == RUN;
        h_wrap  = h_q == HW'(H_TOTAL - 1);
        f_wrap  = h_wrap && v_q == VW'(V_TOTAL - 1);
        state_d = (run && !f_wrap) || i_enable ? RUN : IDLE;
        h_d     = run && !h_wrap ? h_q + HW'(1) : '0;
        v_d     = !run || f_wrap ? '0 : h_wrap ? v_q + VW'(1) : v_q;
    end

    always_comb begin
        h           = h_q;
        v           = v_q;
        active      = run && h_q < HW'(H_ACTIVE) && v_q < VW'(V_ACTIVE);
        hsync       = run && h_q >= HW'(H_ACTIVE + H_FP) && h_q < HW'(H_ACTIVE + H_FP + H_SYNC);
        vsync       = run && v_q >= VW'(V_ACTIVE + V_FP) && v_q < VW'(V_ACTIVE + V_FP + V_SYNC);
        frame_start = run && h_q == '0 && v_q == '0;
        load        = i_enable && (!run || f_wrap);
    end

endmodule

// File: rtl/vid_pattern_gen.sv
// vid_pattern_gen: test-pattern source driving the vid_io stream with programmable
// raster timing; pattern mux on top of vid_timing_gen plus a one-cycle output register.
module vid_pattern_gen
    import vid_pkg::*;
#(
    parameter int DATA_WIDTH = 24,
    parameter int H_ACTIVE   = DEF_H_ACTIVE,
    parameter int H_FP       = DEF_H_FP,
    parameter int H_SYNC     = DEF_H_SYNC,
    parameter int H_BP       = DEF_H_BP,
    parameter int V_ACTIVE   = DEF_V_ACTIVE,
    parameter int V_FP       = DEF_V_FP,
    parameter int V_SYNC     = DEF_V_SYNC,
    parameter int V_BP       = DEF_V_BP,
    parameter bit SYNC_POL   = 1'b1
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  i_enable,
    input  logic [1:0]            i_pattern,
    input  logic [DATA_WIDTH-1:0] i_solid_colour,
    vid_pattern_gen_if.master     vid
);
    localparam int HW = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP);
    localparam int VW = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP);
    localparam logic [15:0] BAR_W = 16'(H_ACTIVE / 8);

    logic [HW-1:0]         h;
    logic [VW-1:0]         v;
    logic                  active, hsync, vsync, frame_start, load;
    pattern_e              pat_q, pat_d;
    logic [DATA_WIDTH-1:0] solid_q, solid_d, data_q, data_d, pix;
    logic                  hs_q, hs_d, vs_q, vs_d, vde_q, vde_d, fs_q, fs_d;
    logic [15:0]           hx, vx, bar;
    logic [2:0]            bi;

    vid_timing_gen #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) u_timing (
        .clk(clk), .n_rst(n_rst), .i_enable(i_enable),
        .h(h), .v(v), .active(active), .hsync(hsync), .vsync(vsync),
        .frame_start(frame_start), .load(load)
    );

    // Bar index saturates at 7 so the last bar absorbs the H_ACTIVE/8 remainder
    always_comb begin
        pat_d   = load ? pattern_e'(i_pattern) : pat_q;
        solid_d = load ? i_solid_colour : solid_q;
        hx      = 16'(h);
        vx      = 16'(v);
        bar     = hx / BAR_W;
        bi      = bar > 16'd7 ? 3'd7 : bar[2:0];
        pix     = pat_q == PAT_BARS  ? DATA_WIDTH'(BAR_COLOUR[bi]) :
                  pat_q == PAT_RAMP  ? DATA_WIDTH'({3{hx[7:0]}}) :
                  pat_q == PAT_SOLID ? solid_q :
                  |((hx ^ vx) & 16'h0020) ? '0 : DATA_WIDTH'(BAR_WHITE);
        data_d  = active ? pix : '0;
        hs_d    = hsync ? SYNC_POL : !SYNC_POL;
        vs_d    = vsync ? SYNC_POL : !SYNC_POL;
        vde_d   = active;
        fs_d    = frame_start;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            pat_q   <= PAT_BARS;
            solid_q <= '0;
            data_q  <= '0;
            hs_q    <= !SYNC_POL;
            vs_q    <= !SYNC_POL;
            vde_q   <= 1'b0;
            fs_q    <= 1'b0;
        end else begin
            pat_q   <= pat_d;
            solid_q <= solid_d;
            data_q  <= data_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            vde_q   <= vde_d;
            fs_q    <= fs_d;
        end
    end

    assign vid.o_vid_data    = data_q;
    assign vid.o_vid_hsync   = hs_q;
    assign vid.o_vid_vsync   = vs_q;
    assign vid.o_vid_VDE     = vde_q;
    assign vid.o_frame_start = fs_q;

endmodule
